ser_rr_sched: RTL and testbench
===============================

# ser_rr_sched

Round-robin scheduler that shares one parallel-to-serial shift engine between `NUM_REQ` requesters. Each requester presents a `DATA_W`-bit word with a request. The block grants one requester at a time, captures its word, and shifts it out LSB-first with valid, last and source-id indications. It sits between the nibble producers and the single serial link and replaces per-source serializers.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 4: word width in bits, 2..16.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req_i` in `NUM_REQ`: per-requester request. The requester holds it, with its data stable, until acked.
- `data_i` in `NUM_REQ*DATA_W`: packed words; requester k occupies `[k*DATA_W +: DATA_W]`.
- `ack_o` out `NUM_REQ`: one-hot, combinational. High in the cycle a word is captured.
- `serial_o` out 1: serial bit, registered.
- `valid_o` out 1: `serial_o` is a frame bit, registered.
- `last_o` out 1: final bit of the frame, registered.
- `src_o` out `$clog2(NUM_REQ)`: index of the requester whose frame is on the line, registered.
- `idle_o` out 1: no frame in flight and none starting next cycle.

## Operation
- The FSM has two states, IDLE and SHIFT. The reset state is IDLE.
- **Capture window:** the cycle is a capture window when `state==IDLE`, or when `state==SHIFT` and the last frame bit is on the line.
- **Grant:** in a capture window with `|req_i`, the requester chosen by the round-robin picker is granted. Its `ack_o` bit goes high, and on the clock edge its word is loaded into the shift register and its index into `src_o`. The FSM is then in SHIFT and the bit counter is cleared.
- **Round-robin:** the search starts at pointer `ptr` and wraps modulo `NUM_REQ`. After a grant to k, `ptr <= (k+1)%NUM_REQ`. `ptr` resets to 0 and is unchanged when nothing is granted.
- **SHIFT:**
  - `serial_o = sreg[0]` and `valid_o = 1`.
  - Each cycle the register shifts right and the counter increments.
  - `last_o = 1` when the counter equals `FRAME_LEN-1`. `FRAME_LEN` is `DATA_W`, or `DATA_W+1` with parity (see Configuration).
  - At the last bit: with a grant, the FSM stays in SHIFT and the new frame starts on the next cycle with no bubble; without a grant, it returns to IDLE.
- **Outputs outside SHIFT:** `serial_o`, `valid_o` and `last_o` are 0. `src_o` holds its last value; it resets to 0.
- `ack_o` is all zeros outside a capture window, even if `req_i` is high.
- `idle_o = (state==IDLE) && !(|req_i)`.
- A requester dropping `req_i` before its ack is never granted. Changes to `req_i`/`data_i` during a frame do not affect that frame.
- Reset asserted mid-frame aborts the frame immediately:
  - all registered outputs go to 0, `ptr` to 0, the FSM to IDLE;
  - `ack_o` is 0 while reset is asserted.

## Timing
- Ack in cycle T means the first frame bit is on `serial_o` in cycle T+1.
- Bit i of the word appears in cycle T+1+i.
- `last_o` is high in cycle T+`FRAME_LEN`, which is also the next capture window.
- With continuous requests, throughput is one frame per `FRAME_LEN` cycles and `valid_o` stays high continuously.
- Grant latency from `req_i` rising while idle is 0 cycles: ack in the same cycle.
- The worst-case wait while others request is `(NUM_REQ-1)*FRAME_LEN` cycles plus the remainder of the current frame.

## Configuration
- **`SER_RR_SCHED_PARITY_EN` defined:**
  - Each frame carries one extra bit after the data MSB: even parity, the XOR of the captured word.
  - `FRAME_LEN = DATA_W+1`.
  - `valid_o` is high on the parity bit and `last_o` marks the parity bit.
- **Undefined:** there is no parity bit and `FRAME_LEN = DATA_W`.

## Structure
- Package `ser_rr_sched_pkg` holds:
  - the `state_t` enum (IDLE, SHIFT);
  - a `CNT_W` helper function giving `$clog2(DATA_W+1)`;
  - a `FRAME_EXTRA` constant, 1 or 0, selected by the macro.
- Sub-module `rr_pick`: a combinational round-robin picker. Inputs are `req` and `ptr`; outputs are a one-hot `gnt`, an encoded `idx` and `any`. It is instantiated once.
- The shift register, counter, pointer and FSM live in the top module.

## Test plan
- **Single word:** reset, then `req_i=4'b0001`, data0=`4'hA` → `ack_o[0]` for one cycle; `serial_o` 0,1,0,1 over the next 4 cycles; `valid_o` 1111; `last_o` on the 4th; `src_o=0`; `idle_o` returns to 1.
- **Fair rotation:** all four requesting continuously with data 1,2,3,4 → grants 0,1,2,3,0…; `valid_o` never drops; each `ack_o` lands on the `last_o` cycle of the previous frame.
- **Pointer wrap:** grant 3 then request 0 and 2 together → 0 is granted first, then 2.
- **Parity build:** data `4'b0111` → frame 1,1,1,0,1 with `last_o` on the 5th bit.
- **Abort:** `reset_n` low at frame bit 2 → `valid_o`, `serial_o`, `last_o`, `src_o` and `ack_o` are 0 immediately. After release with `req_i[2]` high, requester 2 is granted (`ptr=0` search) and its full frame is sent.
- **Withdraw and hold:** `req_i[1]` pulses for one cycle during another frame and is gone at the capture window → no ack to 1. A `data_i` change mid-frame leaves the frame unaltered.

Source files
------------

// File: rtl/ser_rr_sched_pkg.sv
// Shared types and constants for the round-robin serial scheduler.
// Define SER_RR_SCHED_PARITY_EN to append an even-parity bit to every frame.
package ser_rr_sched_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Counter width able to hold the largest bit index of a frame, parity included
   function automatic int unsigned cnt_w(input int unsigned data_w);
      return $clog2(data_w + 1);
   endfunction

`ifdef SER_RR_SCHED_PARITY_EN
   localparam int unsigned FRAME_EXTRA = 1;
`else
   localparam int unsigned FRAME_EXTRA = 0;
`endif

endpackage

// File: rtl/ser_rr_sched_if.sv
// Requester/serial-link bundle of the round-robin serial scheduler.
interface ser_rr_sched_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 4
);
   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_i;
   logic [NUM_REQ*DATA_W-1:0] data_i;
   logic [NUM_REQ-1:0]        ack_o;
   logic                      serial_o;
   logic                      valid_o;
   logic                      last_o;
   logic [IDX_W-1:0]          src_o;
   logic                      idle_o;

   modport slave (
      input  req_i, data_i,
      output ack_o, serial_o, valid_o, last_o, src_o, idle_o
   );

   modport master (
      output req_i, data_i,
      input  ack_o, serial_o, valid_o, last_o, src_o, idle_o
   );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   // Scan from the farthest offset down so the nearest request wins
   always_comb begin
      idx = '0;
      any = |req;
      for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
         if (req[(32'(ptr) + 32'(off)) % NUM_REQ])
            idx = IDX_W'((32'(ptr) + 32'(off)) % NUM_REQ);
      end
      gnt = any ? (NUM_REQ'(1) << idx) : '0;
   end

endmodule

// File: rtl/ser_rr_sched.sv
// Round-robin scheduler sharing one LSB-first shift engine among NUM_REQ requesters.
// Define SER_RR_SCHED_PARITY_EN to append an even-parity bit after the data MSB.
module ser_rr_sched
   import ser_rr_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 4
) (
   input logic          clk,
   input logic          reset_n,
   ser_rr_sched_if.slave bus
);

   localparam int unsigned IDX_W     = $clog2(NUM_REQ);
   localparam int unsigned CNT_W     = cnt_w(DATA_W);
   localparam int unsigned FRAME_LEN = DATA_W + FRAME_EXTRA;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   localparam logic [0:0] ST_IDLE  = IDLE;
   localparam logic [0:0] ST_SHIFT = SHIFT;

   logic [0:0]           state_q, state_d;
   logic [FRAME_LEN-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [IDX_W-1:0]     src_q, src_d;
   logic                 last_q, last_d;

   logic [NUM_REQ-1:0]   pick_gnt;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_any;
   logic                 at_last_c;
   logic                 capture_c;
   logic                 grant_c;
   logic [DATA_W-1:0]    word_c;
   logic [FRAME_LEN-1:0] load_c;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req (bus.req_i),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // A new word may be taken while idle or on the final bit of the current frame
   assign at_last_c = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
   assign capture_c = reset_n && ((state_q == ST_IDLE) || at_last_c);
   assign grant_c   = capture_c && pick_any;
   assign word_c    = bus.data_i[32'(pick_idx) * DATA_W +: DATA_W];

`ifdef SER_RR_SCHED_PARITY_EN
   assign load_c = {^word_c, word_c};
`else
   assign load_c = word_c;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         src_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         src_q   <= src_d;
         last_q  <= last_d;
      end
   end

   // Zero-filled shifting leaves sreg at 0 once a frame drains, so serial idles low
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      src_d   = src_q;

      if (state_q == ST_SHIFT) begin
         sreg_d = sreg_q >> 1;
         if (at_last_c)
            state_d = ST_IDLE;
         else
            cnt_d = cnt_q + 1'b1;
      end

      if (grant_c) begin
         state_d = ST_SHIFT;
         sreg_d  = load_c;
         cnt_d   = '0;
         src_d   = pick_idx;
         ptr_d   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end

      last_d = (state_d == ST_SHIFT) && (cnt_d == LAST_CNT);
   end

   assign bus.ack_o    = grant_c ? pick_gnt : '0;
   assign bus.serial_o = sreg_q[0];
   assign bus.valid_o  = (state_q == ST_SHIFT);
   assign bus.last_o   = last_q;
   assign bus.src_o    = src_q;
   assign bus.idle_o   = (state_q == ST_IDLE) && !(|bus.req_i);

endmodule

// File: tb/tb_ser_rr_sched.sv
// Directed self-checking bench for ser_rr_sched with NUM_REQ=4, DATA_W=4.
module tb_ser_rr_sched;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ser_rr_sched_if #(.NUM_REQ(4), .DATA_W(4)) bus ();

   ser_rr_sched #(.NUM_REQ(4), .DATA_W(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   typedef struct {
      logic        rst_n;
      logic [3:0]  req;
      logic [15:0] data;
      logic [3:0]  ack;
      logic        ser;
      logic        vld;
      logic        lst;
      logic [1:0]  src;
      logic        idl;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst_n, input logic [3:0] req, input logic [15:0] data,
                      input logic [3:0] ack, input logic ser, input logic vld,
                      input logic lst, input logic [1:0] src, input logic idl);
      vec_t v;
      v.rst_n = rst_n; v.req = req; v.data = data; v.ack = ack;
      v.ser = ser; v.vld = vld; v.lst = lst; v.src = src; v.idl = idl;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int row, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
      end
   endtask

   task automatic chk_outputs(input int row, input logic [3:0] ack, input logic ser,
                              input logic vld, input logic lst, input logic [1:0] src,
                              input logic idl);
      chk("ack_o",    row, 16'(bus.ack_o),    16'(ack));
      chk("serial_o", row, 16'(bus.serial_o), 16'(ser));
      chk("valid_o",  row, 16'(bus.valid_o),  16'(vld));
      chk("last_o",   row, 16'(bus.last_o),   16'(lst));
      chk("src_o",    row, 16'(bus.src_o),    16'(src));
      chk("idle_o",   row, 16'(bus.idle_o),   16'(idl));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_i  = '0;
      bus.data_i = '0;
      reset_n    = 1'b0;
      repeat (2) @(posedge clk);

`ifndef SER_RR_SCHED_PARITY_EN
      // Single word 0xA from requester 0, then a held-reset request is not acked
      add(0, 4'h0, 16'h000A, 4'h0, 0, 0, 0, 0, 1);
      add(0, 4'h1, 16'h000A, 4'h0, 0, 0, 0, 0, 0);
      add(1, 4'h1, 16'h000A, 4'h1, 0, 0, 0, 0, 0);
      add(1, 4'h0, 16'h000A, 4'h0, 0, 1, 0, 0, 0);
      add(1, 4'h0, 16'h000A, 4'h0, 1, 1, 0, 0, 0);
      add(1, 4'h0, 16'h000A, 4'h0, 0, 1, 0, 0, 0);
      add(1, 4'h0, 16'h000A, 4'h0, 1, 1, 1, 0, 0);
      add(1, 4'h0, 16'h000A, 4'h0, 0, 0, 0, 0, 1);
      // Fair rotation, data 1,2,3,4, back-to-back frames
      add(0, 4'h0, 16'h0000, 4'h0, 0, 0, 0, 0, 1);
      add(1, 4'hF, 16'h4321, 4'h1, 0, 0, 0, 0, 0);
      add(1, 4'hF, 16'h4321, 4'h0, 1, 1, 0, 0, 0);
      add(1, 4'hF, 16'h4321, 4'h0, 0, 1, 0, 0, 0);
      add(1, 4'hF, 16'h4321, 4'h0, 0, 1, 0, 0, 0);
      add(1, 4'hF, 16'h4321, 4'h2, 0, 1, 1, 0, 0);
      add(1, 4'hF, 16'h4321, 4'h0, 0, 1, 0, 1, 0);
      add(1, 4'hF, 16'h4321, 4'h0, 1, 1, 0, 1, 0);
      add(1, 4'hF, 16'h4321, 4'h0, 0, 1, 0, 1, 0);
      add(1, 4'hF, 16'h4321, 4'h4, 0, 1, 1, 1, 0);
      add(1, 4'hF, 16'h4321, 4'h0, 1, 1, 0, 2, 0);
      add(1, 4'hF, 16'h4321, 4'h0, 1, 1, 0, 2, 0);
      add(1, 4'hF, 16'h4321, 4'h0, 0, 1, 0, 2, 0);
      add(1, 4'hF, 16'h4321, 4'h8, 0, 1, 1, 2, 0);
      add(1, 4'hF, 16'h4321, 4'h0, 0, 1, 0, 3, 0);
      add(1, 4'hF, 16'h4321, 4'h0, 0, 1, 0, 3, 0);
      add(1, 4'hF, 16'h4321, 4'h0, 1, 1, 0, 3, 0);
      add(1, 4'h0, 16'h4321, 4'h0, 0, 1, 1, 3, 0);
      // Pointer wrapped to 0: requesters 0 and 2 together, 0 first then 2
      add(1, 4'h5, 16'h0905, 4'h1, 0, 0, 0, 3, 0);
      add(1, 4'h4, 16'h0905, 4'h0, 1, 1, 0, 0, 0);
      add(1, 4'h4, 16'h0905, 4'h0, 0, 1, 0, 0, 0);
      add(1, 4'h4, 16'h0905, 4'h0, 1, 1, 0, 0, 0);
      add(1, 4'h4, 16'h0905, 4'h4, 0, 1, 1, 0, 0);
      // Abort at frame bit 2, then requester 2 resent in full from ptr 0
      add(1, 4'h0, 16'h0905, 4'h0, 1, 1, 0, 2, 0);
      add(1, 4'h0, 16'h0905, 4'h0, 0, 1, 0, 2, 0);
      add(0, 4'h4, 16'h0905, 4'h0, 0, 0, 0, 0, 0);
      add(1, 4'h4, 16'h0905, 4'h4, 0, 0, 0, 0, 0);
      add(1, 4'h0, 16'h0905, 4'h0, 1, 1, 0, 2, 0);
      add(1, 4'h0, 16'h0905, 4'h0, 0, 1, 0, 2, 0);
      add(1, 4'h0, 16'h0905, 4'h0, 0, 1, 0, 2, 0);
      add(1, 4'h0, 16'h0905, 4'h0, 1, 1, 1, 2, 0);
      add(1, 4'h0, 16'h0905, 4'h0, 0, 0, 0, 2, 1);
      // Withdrawn pulse on requester 1 and mid-frame data change
      add(1, 4'h1, 16'h000C, 4'h1, 0, 0, 0, 2, 0);
      add(1, 4'h2, 16'h0003, 4'h0, 0, 1, 0, 0, 0);
      add(1, 4'h0, 16'h0003, 4'h0, 0, 1, 0, 0, 0);
      add(1, 4'h0, 16'h0003, 4'h0, 1, 1, 0, 0, 0);
      add(1, 4'h0, 16'h0003, 4'h0, 1, 1, 1, 0, 0);
      add(1, 4'h0, 16'h0003, 4'h0, 0, 0, 0, 0, 1);

      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         reset_n    = vecs[i].rst_n;
         bus.req_i  = vecs[i].req;
         bus.data_i = vecs[i].data;
         @(negedge clk);
         chk_outputs(i, vecs[i].ack, vecs[i].ser, vecs[i].vld, vecs[i].lst,
                     vecs[i].src, vecs[i].idl);
      end
`else
      begin
         logic [4:0] pbits;
         pbits = 5'b10111;
         @(negedge clk);
         chk_outputs(0, 4'h0, 0, 0, 0, 0, 1);
         @(posedge clk);
         #1;
         reset_n    = 1'b1;
         bus.req_i  = 4'h1;
         bus.data_i = 16'h0007;
         @(negedge clk);
         chk_outputs(1, 4'h1, 0, 0, 0, 0, 0);
         for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.req_i = 4'h0;
            @(negedge clk);
            chk_outputs(2 + i, 4'h0, pbits[i], 1, (i == 4), 0, 0);
         end
         @(posedge clk);
         @(negedge clk);
         chk_outputs(7, 4'h0, 0, 0, 0, 0, 1);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
